irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//  Interrupt scheduler in front of the proc core. Arbitrates two sources: keypad button (raw async)
//  and Ethernet receive events (valid/ready + 32b payload). Serialises them into one-cycle irq_out
//  pulses and holds the serviced payload on irq_data for RDI. Frees the next grant on rti/rsi.
// PARAMETERS
//  DATA_W          32      payload / irq_data width
//  ETH_DEPTH       4       Ethernet event FIFO entries (power of 2, >=2)
//  SYNC_STAGES     2       flops in key_in synchroniser (>=2)
//  DEBOUNCE_CYC    50000   stable cycles required on key (used only with IRQ_DEBOUNCE_EN)
//  KEY_CODE        32'h0000_0001  value on irq_data when the key is the serviced source
// PORTS
//  clk         in   1       clock
//  rst_n       in   1       reset, asynchronous, active-low
//  key_in      in   1       raw button, active-high, asynchronous to clk
//  eth_valid   in   1       Ethernet event offered
//  eth_data    in   DATA_W  Ethernet event payload
//  eth_ready   out  1       FIFO can accept; push = eth_valid & eth_ready
//  rti         in   1       single-cycle pulse from core: return from interrupt
//  rsi         in   1       single-cycle pulse from core: service done, stay in handler
//  irq_out     out  1       one-cycle interrupt request to core
//  irq_data    out  DATA_W  payload of the interrupt currently/last granted
//  irq_src     out  2       source of irq_data: 00 none, 01 key, 10 eth
//  irq_busy    out  1       high in REQ and SERVICE
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, key_pend=0, last_src=NONE; irq_out=0, irq_data=0, irq_src=00,
//   irq_busy=0, eth_ready=1. Reset mid-service discards pending key and all FIFO entries.
//  Key path: key_in -> SYNC_STAGES sync -> rising-edge detect -> sets key_pend. Raw rise sampled
//   at edge N sets key_pend at edge N+SYNC_STAGES+1. Further rises while key_pend=1 merge (no count).
//  Eth path: eth_ready = (count < ETH_DEPTH), registered-count based, no push-through when full.
//   Push and pop in same cycle legal when not full; count unchanged.
//  FSM IRQ_IDLE -> IRQ_REQ -> IRQ_SERVICE -> IRQ_IDLE.
//   IDLE: if key_pend | !empty, choose winner, go REQ next edge; on that edge load irq_data/irq_src,
//    clear key_pend (key) or pop FIFO head (eth), update last_src.
//   Arbitration: key wins, except when last_src==KEY and FIFO non-empty -> eth wins (no starvation).
//   REQ: irq_out=1 for exactly this cycle; always -> SERVICE. rti/rsi in REQ ignored.
//   SERVICE: wait; rti or rsi (either, or both same cycle) -> IDLE. New events keep queueing.
//   rti/rsi in IDLE ignored. Minimum spacing between irq_out pulses: 3 cycles.
//  Key rise accepted in the same cycle key_pend is cleared by grant -> key_pend stays 1 (set wins).
//  irq_data/irq_src hold value after return until next grant (RDI may read late).
// CONFIGURATION
//  IRQ_DEBOUNCE_EN defined: synced key must hold a new level for DEBOUNCE_CYC consecutive cycles
//   (counter restarts on any change) before the debounced level updates; edge detect uses the
//   debounced level, so key latency grows by DEBOUNCE_CYC cycles and glitches shorter are dropped.
//  Not defined: edge detect runs on synchroniser output directly; no counter instantiated.
// STRUCTURE
//  irq_pkg: irq_state_t {IRQ_IDLE, IRQ_REQ, IRQ_SERVICE}; irq_src_t {SRC_NONE=2'b00,
//   SRC_KEY=2'b01, SRC_ETH=2'b10}; default KEY_CODE constant.
//  Sub-module irq_event_fifo (DATA_W, ETH_DEPTH): sync FIFO, push/pop/full/empty/count, head data
//   visible combinationally. Sync, debounce, arbitration and FSM stay in irq_controller.
// TESTING
//  1 key_in 0->1 held, no eth -> irq_out pulse at edge N+SYNC_STAGES+2, irq_data=1, irq_src=01.
//  2 Push eth 0xA5A5_0001 with rti never sent -> one irq_out, irq_busy stays 1, no 2nd pulse;
//    then rti -> IDLE; second pushed 0xA5A5_0002 -> irq_out 2 cycles later, irq_data=0xA5A5_0002.
//  3 Key and eth pending same cycle -> key served first; after rti eth served even if key re-pressed;
//    then key served.
//  4 Push 5 events with no service -> eth_ready=0 after 4th, 5th not accepted; drain order 1..4.
//  5 Assert rst_n=0 in SERVICE with 2 events queued -> all outputs reset values, no irq after release.
//  6 IRQ_DEBOUNCE_EN, DEBOUNCE_CYC=8: key glitch of 5 cycles -> no irq; 12-cycle press -> one irq.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg
//   Shared types and constants for the interrupt controller slice.
//   irq_state_t : scheduler FSM states
//   irq_src_t   : encoding of the serviced source, as seen on irq_src
//   KEY_CODE_DEFAULT : payload reported on irq_data when the key is serviced
package irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_KEY  = 2'b01,
    SRC_ETH  = 2'b10
  } irq_src_t;

  localparam logic [31:0] KEY_CODE_DEFAULT = 32'h0000_0001;

endpackage

// File: rtl/irq_controller_if.sv
// irq_controller_if
//   Bundles the event inputs, the core return pulses and the interrupt
//   outputs of irq_controller.
//   master : the environment side (keypad, Ethernet receiver, core)
//   slave  : the controller side
//   Signals: key_in, eth_valid, eth_data, eth_ready, rti, rsi,
//            irq_out, irq_data, irq_src, irq_busy
interface irq_controller_if
  import irq_pkg::*;
#(
  parameter int DATA_W = 32
) ();

  logic              key_in;
  logic              eth_valid;
  logic [DATA_W-1:0] eth_data;
  logic              eth_ready;
  logic              rti;
  logic              rsi;
  logic              irq_out;
  logic [DATA_W-1:0] irq_data;
  irq_src_t          irq_src;
  logic              irq_busy;

  modport master (
    output key_in, eth_valid, eth_data, rti, rsi,
    input  eth_ready, irq_out, irq_data, irq_src, irq_busy
  );

  modport slave (
    input  key_in, eth_valid, eth_data, rti, rsi,
    output eth_ready, irq_out, irq_data, irq_src, irq_busy
  );

endinterface

// File: rtl/irq_event_fifo.sv
// irq_event_fifo
//   Synchronous FIFO queueing Ethernet receive payloads until the scheduler
//   grants them. The head entry is visible combinationally on head_data.
//   Ports: clk, rst_n (async, active-low), push/push_data, pop,
//          head_data, full, empty, count.
//   Pushes while full and pops while empty are dropped.
module irq_event_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// irq_controller
//   Interrupt scheduler in front of the processor core. Arbitrates the keypad
//   button and queued Ethernet receive events, issues one-cycle irq_out
//   pulses and holds the granted payload on irq_data/irq_src until the next
//   grant. A new grant is possible only after the core answers with rti/rsi.
//   Ports: clk, rst_n (async, active-low), bus (irq_controller_if.slave).
//   Optional feature: define IRQ_DEBOUNCE_EN to debounce the synchronised
//   key over DEBOUNCE_CYC stable cycles before edge detection.
module irq_controller
  import irq_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                ETH_DEPTH    = 4,
  parameter int                SYNC_STAGES  = 2,
  parameter int                DEBOUNCE_CYC = 50000,
  parameter logic [DATA_W-1:0] KEY_CODE     = DATA_W'(KEY_CODE_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  irq_controller_if.slave  bus
);

  localparam int CW = $clog2(ETH_DEPTH) + 1;

  // ---------------- key path ----------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   key_sync;
  logic                   key_level;
  logic                   key_prev_q, key_prev_d;
  logic                   key_rise_q, key_rise_d;
  logic                   key_pend_q, key_pend_d;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.key_in};
  assign key_sync = sync_q[SYNC_STAGES-1];

`ifdef IRQ_DEBOUNCE_EN
  localparam int DCW = $clog2(DEBOUNCE_CYC + 1);

  logic           key_deb_q, key_deb_d;
  logic [DCW-1:0] deb_cnt_q, deb_cnt_d;

  // The debounced level follows the synced key only after it has differed
  // for DEBOUNCE_CYC consecutive cycles; any bounce back restarts the count.
  always_comb begin
    key_deb_d = key_deb_q;
    deb_cnt_d = '0;
    if (key_sync != key_deb_q) begin
      if (deb_cnt_q == DCW'(DEBOUNCE_CYC - 1)) key_deb_d = key_sync;
      else                                     deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_deb_q <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      key_deb_q <= key_deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign key_level = key_deb_q;
`else
  assign key_level = key_sync;
`endif

  logic grant_key;
  logic grant_eth;

  // The rise is registered once before reaching key_pend, giving a raw rise
  // sampled at edge N a pending key at edge N+SYNC_STAGES+1. A rise that
  // lands on the grant cycle keeps key_pend set.
  always_comb begin
    key_prev_d = key_level;
    key_rise_d = key_level & ~key_prev_q;
    key_pend_d = (key_pend_q & ~grant_key) | key_rise_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      key_prev_q <= 1'b0;
      key_rise_q <= 1'b0;
      key_pend_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      key_prev_q <= key_prev_d;
      key_rise_q <= key_rise_d;
      key_pend_q <= key_pend_d;
    end
  end

  // ---------------- Ethernet path ----------------
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              fifo_push;

  assign bus.eth_ready = (fifo_count < CW'(ETH_DEPTH));
  assign fifo_push     = bus.eth_valid & ~fifo_full;

  irq_event_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (ETH_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (bus.eth_data),
    .pop       (grant_eth),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ---------------- arbitration + FSM ----------------
  irq_state_t        state_q;
  irq_src_t          last_src_q;
  irq_src_t          irq_src_q;
  logic [DATA_W-1:0] irq_data_q;
  logic              irq_out_q;
  logic              irq_busy_q;
  logic              pick_eth;
  logic              in_idle;

  // Key normally wins; right after a key grant a waiting Ethernet event
  // goes first so a chattering key cannot starve the queue.
  assign in_idle   = (state_q == IRQ_IDLE);
  assign pick_eth  = ~fifo_empty & (~key_pend_q | (last_src_q == SRC_KEY));
  assign grant_eth = in_idle & pick_eth;
  assign grant_key = in_idle & key_pend_q & ~pick_eth;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IRQ_IDLE;
      last_src_q <= SRC_NONE;
      irq_src_q  <= SRC_NONE;
      irq_data_q <= '0;
      irq_out_q  <= 1'b0;
      irq_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (grant_key || grant_eth) begin
            state_q    <= IRQ_REQ;
            irq_out_q  <= 1'b1;
            irq_busy_q <= 1'b1;
            irq_data_q <= grant_key ? KEY_CODE : fifo_head;
            irq_src_q  <= grant_key ? SRC_KEY : SRC_ETH;
            last_src_q <= grant_key ? SRC_KEY : SRC_ETH;
          end
        end
        IRQ_REQ: begin
          state_q   <= IRQ_SERVICE;
          irq_out_q <= 1'b0;
        end
        IRQ_SERVICE: begin
          if (bus.rti || bus.rsi) begin
            state_q    <= IRQ_IDLE;
            irq_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IRQ_IDLE;
          irq_out_q  <= 1'b0;
          irq_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_out  = irq_out_q;
  assign bus.irq_busy = irq_busy_q;
  assign bus.irq_data = irq_data_q;
  assign bus.irq_src  = irq_src_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller
//   Self-checking bench for irq_controller. A transaction-level model
//   (payload queue, pending-key flag, key sample history, grant phase) is
//   stepped on each rising edge and compared against the DUT every falling
//   edge. Directed scenarios pin the model with literal expectations, then
//   a randomized phase exercises arbitration, back-pressure and returns.
module tb_irq_controller;
  import irq_pkg::*;

  localparam int DATA_W    = 32;
  localparam int ETH_DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  irq_controller_if #(.DATA_W(DATA_W)) bus ();

  irq_controller #(
    .DATA_W       (DATA_W),
    .ETH_DEPTH    (ETH_DEPTH),
    .SYNC_STAGES  (2),
    .DEBOUNCE_CYC (8),
    .KEY_CODE     (32'h0000_0001)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  bit   model_en = 1'b1;
  logic cur_key = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];
  bit          m_pend;
  int          m_last;
  int          m_phase;
  logic [31:0] m_data;
  logic [1:0]  m_src;
  bit          m_h[4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pend  = 1'b0;
      m_last  = 0;
      m_phase = 0;
      m_data  = '0;
      m_src   = 2'b00;
      for (int i = 0; i < 4; i++) m_h[i] = 1'b0;
    end else begin
      bit rise, gk, ge, push;
      rise = m_h[2] & ~m_h[3];
      push = bus.eth_valid && (m_q.size() < ETH_DEPTH);
      gk = 1'b0;
      ge = 1'b0;
      if (m_phase == 0 && (m_pend || m_q.size() > 0)) begin
        if (m_q.size() > 0 && (!m_pend || m_last == 1)) ge = 1'b1;
        else                                            gk = 1'b1;
      end
      case (m_phase)
        0:       if (gk || ge) m_phase = 1;
        1:       m_phase = 2;
        default: if (bus.rti || bus.rsi) m_phase = 0;
      endcase
      if (gk) begin
        m_data = 32'h0000_0001;
        m_src  = 2'b01;
        m_last = 1;
      end
      if (ge) begin
        m_data = m_q.pop_front();
        m_src  = 2'b10;
        m_last = 2;
      end
      if (push) m_q.push_back(bus.eth_data);
      m_pend = (m_pend && !gk) || rise;
      m_h[3] = m_h[2];
      m_h[2] = m_h[1];
      m_h[1] = m_h[0];
      m_h[0] = bus.key_in;
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      checkOutput("irq_out",   {31'b0, bus.irq_out},   {31'b0, m_phase == 1});
      checkOutput("irq_busy",  {31'b0, bus.irq_busy},  {31'b0, m_phase != 0});
      checkOutput("eth_ready", {31'b0, bus.eth_ready}, {31'b0, m_q.size() < ETH_DEPTH});
      checkOutput("irq_data",  bus.irq_data, m_data);
      checkOutput("irq_src",   {30'b0, bus.irq_src}, {30'b0, m_src});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic key, input logic valid,
                               input logic [31:0] data, input logic rti,
                               input logic rsi);
    cur_key       = key;
    bus.key_in    = key;
    bus.eth_valid = valid;
    bus.eth_data  = data;
    bus.rti       = rti;
    bus.rsi       = rsi;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(cur_key, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic pushEvent(input logic [31:0] data);
    applyStimulus(cur_key, 1'b1, data, 1'b0, 1'b0);
  endtask

  task automatic finishService();
    idleCycle();
    applyStimulus(cur_key, 1'b0, 32'h0, 1'b1, 1'b0);
    idleCycle();
  endtask

  // Leaves REQ, returns with rti, and expects the next grant one edge later.
  task automatic serviceAndExpect(input logic [1:0] src, input logic [31:0] data);
    idleCycle();
    applyStimulus(cur_key, 1'b0, 32'h0, 1'b1, 1'b0);
    idleCycle();
    checkOutput("grant_pulse", {31'b0, bus.irq_out}, 32'd1);
    checkOutput("grant_src",   {30'b0, bus.irq_src}, {30'b0, src});
    checkOutput("grant_data",  bus.irq_data, data);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_irq_out"},   {31'b0, bus.irq_out},   32'd0);
    checkOutput({tag, "_irq_data"},  bus.irq_data,           32'd0);
    checkOutput({tag, "_irq_src"},   {30'b0, bus.irq_src},   32'd0);
    checkOutput({tag, "_irq_busy"},  {31'b0, bus.irq_busy},  32'd0);
    checkOutput({tag, "_eth_ready"}, {31'b0, bus.eth_ready}, 32'd1);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkResetValues("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pulses;
    bus.key_in    = 1'b0;
    bus.eth_valid = 1'b0;
    bus.eth_data  = '0;
    bus.rti       = 1'b0;
    bus.rsi       = 1'b0;
    #2;
    doReset();

`ifndef IRQ_DEBOUNCE_EN
    // Key press: sampled at edge N, pulse at edge N+4.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idleCycle();
    idleCycle();
    idleCycle();
    checkOutput("key_no_early_pulse", {31'b0, bus.irq_out}, 32'd0);
    idleCycle();
    checkOutput("key_pulse", {31'b0, bus.irq_out}, 32'd1);
    checkOutput("key_data",  bus.irq_data, 32'h0000_0001);
    checkOutput("key_src",   {30'b0, bus.irq_src}, 32'd1);
    cur_key = 1'b0;
`endif
    finishService();

    // Unanswered eth interrupt blocks the second one until rti.
    pushEvent(32'hA5A5_0001);
    idleCycle();
    checkOutput("eth1_pulse", {31'b0, bus.irq_out}, 32'd1);
    checkOutput("eth1_data",  bus.irq_data, 32'hA5A5_0001);
    checkOutput("eth1_src",   {30'b0, bus.irq_src}, 32'd2);
    pushEvent(32'hA5A5_0002);
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("eth_wait_no_pulse", {31'b0, bus.irq_out},  32'd0);
      checkOutput("eth_wait_busy",     {31'b0, bus.irq_busy}, 32'd1);
    end
    serviceAndExpect(2'b10, 32'hA5A5_0002);

`ifndef IRQ_DEBOUNCE_EN
    // Key vs eth both pending: key first, then eth despite re-press, then key.
    finishService();
    pushEvent(32'h0000_0033);
    idleCycle();
    checkOutput("arb_first_eth_src", {30'b0, bus.irq_src}, 32'd2);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    pushEvent(32'hC0DE_0003);
    for (int i = 0; i < 4; i++) idleCycle();
    serviceAndExpect(2'b01, 32'h0000_0001);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idleCycle();
    serviceAndExpect(2'b10, 32'hC0DE_0003);
    serviceAndExpect(2'b01, 32'h0000_0001);

    // Fill the FIFO while the key interrupt is unanswered.
    cur_key = 1'b0;
    for (int i = 1; i <= 4; i++) pushEvent(32'h4000_0000 + i);
    checkOutput("full_not_ready", {31'b0, bus.eth_ready}, 32'd0);
    pushEvent(32'h4000_0005);
    checkOutput("full_still_not_ready", {31'b0, bus.eth_ready}, 32'd0);
    for (int i = 1; i <= 4; i++) serviceAndExpect(2'b10, 32'h4000_0000 + i);
    idleCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      idleCycle();
      checkOutput("fifth_dropped", {31'b0, bus.irq_out}, 32'd0);
    end

    // Reset in SERVICE with two queued events.
    pushEvent(32'h5000_0000);
    idleCycle();
    pushEvent(32'h5000_0001);
    pushEvent(32'h5000_0002);
    checkOutput("pre_reset_busy", {31'b0, bus.irq_busy}, 32'd1);
    doReset();
    for (int i = 0; i < 10; i++) begin
      idleCycle();
      checkOutput("post_reset_no_irq", {31'b0, bus.irq_out}, 32'd0);
    end
`else
    // Debounce: 5-cycle glitch is dropped, 12-cycle press gives one pulse.
    model_en = 1'b0;
    finishService();
    doReset();
    pulses = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      if (bus.irq_out) pulses++;
    end
    checkOutput("deb_glitch_pulses", pulses, 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      if (bus.irq_out) pulses++;
    end
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      if (bus.irq_out) pulses++;
    end
    checkOutput("deb_press_pulses", pulses, 32'd1);
    doReset();
    model_en = 1'b1;
`endif

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 2000; n++) begin
      logic k;
      k = cur_key;
`ifndef IRQ_DEBOUNCE_EN
      if ($urandom_range(0, 15) == 0) k = ~k;
`else
      k = 1'b0;
`endif
      applyStimulus(k, ($urandom_range(0, 2) == 0), $urandom,
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 499) == 0) doReset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
